// File: rtl/subtractor_32bit_seq_pkg.sv
// Shared definitions for the slice-serial subtractor: FSM state encoding and
// default operand/slice widths.
package subtractor_32bit_seq_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/subtractor_32bit_seq_sub_8bit.sv
// Combinational W-bit slice subtractor: diff = a - b - bin, bout = borrow out.
module sub_8bit #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         bin_i,
    output logic [W-1:0] diff_o,
    output logic         bout_o
);

    logic [W:0] wide;

    // The extra MSB of the widened difference is set exactly when a < b + bin.
    assign wide   = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, bin_i};
    assign diff_o = wide[W-1:0];
    assign bout_o = wide[W];

endmodule

// File: rtl/subtractor_32bit_seq.sv
// Multi-cycle WIDTH-bit subtractor, one SLICE_W slice per cycle, LSB first.
// Optional registered underflow output enabled by macro SUB_UNDERFLOW_FLAG_EN.
module subtractor_32bit_seq
    import subtractor_32bit_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SLICE_W = DEF_SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff
`ifdef SUB_UNDERFLOW_FLAG_EN
    ,
    output logic             underflow
`endif
);

    localparam int unsigned NSLICES = WIDTH / SLICE_W;
    localparam int unsigned IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [SLICE_W-1:0] slice_a, slice_b, slice_diff;
    logic               slice_bout;

`ifdef SUB_UNDERFLOW_FLAG_EN
    logic               uf_q, uf_d;
`endif

    assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];

    sub_8bit #(
        .W(SLICE_W)
    ) u_slice (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .bin_i  (borrow_q),
        .diff_o (slice_diff),
        .bout_o (slice_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        idx_d    = idx_q;
`ifdef SUB_UNDERFLOW_FLAG_EN
        uf_d     = uf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = 1'b0;
                    idx_d    = '0;
`ifdef SUB_UNDERFLOW_FLAG_EN
                    uf_d     = 1'b0;
`endif
                    state_d  = CALC;
                end
            end
            CALC: begin
                diff_d[idx_q*SLICE_W +: SLICE_W] = slice_diff;
                borrow_d = slice_bout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
`ifdef SUB_UNDERFLOW_FLAG_EN
                    uf_d    = slice_bout;
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
`ifdef SUB_UNDERFLOW_FLAG_EN
            uf_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            idx_q    <= idx_d;
`ifdef SUB_UNDERFLOW_FLAG_EN
            uf_q     <= uf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
`ifdef SUB_UNDERFLOW_FLAG_EN
    assign underflow = uf_q;
`endif

endmodule

// File: tb/tb_subtractor_32bit_seq.sv
// Directed scoreboard bench for subtractor_32bit_seq; checks underflow when
// SUB_UNDERFLOW_FLAG_EN is defined.
module tb_subtractor_32bit_seq;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SLICE_W = 8;
    localparam int unsigned LATENCY = WIDTH / SLICE_W + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
`ifdef SUB_UNDERFLOW_FLAG_EN
    logic             underflow;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             uf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    subtractor_32bit_seq #(
        .WIDTH   (WIDTH),
        .SLICE_W (SLICE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff)
`ifdef SUB_UNDERFLOW_FLAG_EN
        ,
        .underflow (underflow)
`endif
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold = DONE cycles with out_ready low, poke = junk in_valid during CALC.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input int hold, input bit poke);
        exp_t e;
        int   n;
        int   lat;
        e = '0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", WIDTH'(in_ready), WIDTH'(1));
        a         = av;
        b         = bv;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        exp_q.push_back('{d: av - bv, uf: (av < bv)});
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
            if (poke && lat == 2) begin
                check("in_ready_in_calc", WIDTH'(in_ready), WIDTH'(0));
                a        = ~av;
                b        = av ^ bv;
                in_valid = 1'b1;
            end
        end while (!out_valid && lat < 20);
        in_valid = 1'b0;
        check("latency", WIDTH'(lat), WIDTH'(LATENCY));
        check("in_ready_in_done", WIDTH'(in_ready), WIDTH'(0));
        for (int i = 0; i < hold; i++) begin
            check("hold_out_valid", WIDTH'(out_valid), WIDTH'(1));
            check("hold_diff", diff, av - bv);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("out_valid_at_handshake", WIDTH'(out_valid), WIDTH'(1));
        check("scoreboard_depth", WIDTH'(exp_q.size()), WIDTH'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("diff", diff, e.d);
`ifdef SUB_UNDERFLOW_FLAG_EN
            check("underflow", WIDTH'(underflow), WIDTH'(e.uf));
`endif
        end
        @(negedge clk);
        check("out_valid_after_exit", WIDTH'(out_valid), WIDTH'(0));
        check("in_ready_after_exit", WIDTH'(in_ready), WIDTH'(1));
        check("diff_held_in_idle", diff, e.d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", WIDTH'(out_valid), WIDTH'(0));
        check("reset_diff", diff, '0);
`ifdef SUB_UNDERFLOW_FLAG_EN
        check("reset_underflow", WIDTH'(underflow), WIDTH'(0));
`endif
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", WIDTH'(in_ready), WIDTH'(1));

        run_op(32'h0000_0005, 32'h0000_0003, 0, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0001, 0, 1'b0);
        run_op(32'h0000_0100, 32'h0000_0001, 0, 1'b0);
        run_op(32'h1234_5678, 32'h0204_0608, 10, 1'b0);
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_op($urandom, $urandom, 0, 1'b0);
        end

        // Abort: reset lands on the second CALC cycle.
        a        = 32'h0000_00F0;
        b        = 32'h0000_000F;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", WIDTH'(out_valid), WIDTH'(0));
        check("abort_diff", diff, '0);
        check("abort_in_ready", WIDTH'(in_ready), WIDTH'(1));
`ifdef SUB_UNDERFLOW_FLAG_EN
        check("abort_underflow", WIDTH'(underflow), WIDTH'(0));
`endif
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_result", WIDTH'(seen), WIDTH'(0));

        run_op(32'h0001_0000, 32'h0000_0001, 0, 1'b0);
        check("scoreboard_drained", WIDTH'(exp_q.size()), WIDTH'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
